// File: rtl/time_entry_loader_pkg.sv
// Shared timer-chain constants: FSM state codes, BCD limits and the digit bundle type.
package time_entry_loader_pkg;
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int CNT_W      = 3;

  localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT    = 4'd9;

  localparam logic [1:0] ST_ENTRY  = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_ARMED  = 2'd2;
  localparam logic [1:0] ST_PAUSED = 2'd3;

  // [0]=sec_ones, [1]=sec_tens, [2]=min_ones, [3]=min_tens
  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  // A loadable entry needs a legal seconds-tens digit and a nonzero value.
  function automatic logic entry_ok(input digits_t d);
    return (d[1] <= MAX_SEC_TENS) && (d != '0);
  endfunction
endpackage

// File: rtl/time_entry_loader_bcd_entry_shift.sv
// Four-digit BCD keypad shift register; saturates at four digits, drops non-BCD codes.
module bcd_entry_shift
  import time_entry_loader_pkg::*;
(
  input  logic               clock,
  input  logic               clearn,
  input  logic               clr,
  input  logic               shift,
  input  logic [DIGIT_W-1:0] key,
  output digits_t            digits
);

  logic [CNT_W-1:0] count;
  logic             accept;

  assign accept = shift && (key <= MAX_DIGIT) && (count < CNT_W'(NUM_DIGITS));

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      digits <= '0;
      count  <= '0;
    end else if (clr) begin
      digits <= '0;
      count  <= '0;
    end else if (accept) begin
      digits <= {digits[NUM_DIGITS-2:0], key};
      count  <= count + 1'b1;
    end
  end

endmodule

// File: rtl/time_entry_loader.sv
// Keypad front end of the countdown chain: collects MM:SS, parallel-loads the
// counters, then gates their count enable until zero with pause/resume.
module time_entry_loader
  import time_entry_loader_pkg::*;
#(
  parameter int LOAD_CYCLES = 1
) (
  input  logic         clock,
  input  logic         clearn,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  input  logic         start,
  input  logic         stop,
  input  logic         clear_entry,
  input  logic         timer_zero,
  output logic [3:0]   data_sec_ones,
  output logic [3:0]   data_sec_tens,
  output logic [3:0]   data_min_ones,
  output logic [3:0]   data_min_tens,
  output logic         loadn,
  output logic         run,
  output logic [1:0]   state_o,
  output logic         entry_err,
  output logic         done
);

  localparam logic [1:0] LOAD_LAST = 2'(LOAD_CYCLES - 1);

  logic [1:0] state, state_nxt;
  logic [1:0] load_cnt;
  logic       clr, shift, err_nxt, done_nxt;
  digits_t    digits;

  bcd_entry_shift u_entry (
    .clock  (clock),
    .clearn (clearn),
    .clr    (clr),
    .shift  (shift),
    .key    (key_code),
    .digits (digits)
  );

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    shift     = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_ENTRY: begin
        if (clear_entry) clr = 1'b1;
        else if (start) begin
          if (entry_ok(digits)) state_nxt = ST_LOAD;
          else                  err_nxt   = 1'b1;
        end else shift = key_valid;
      end
      ST_LOAD: begin
        if (clear_entry) begin
          clr       = 1'b1;
          state_nxt = ST_ENTRY;
        end else if (load_cnt == LOAD_LAST) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (timer_zero) begin
          clr       = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_ENTRY;
        end else if (stop) state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (clear_entry) begin
          clr       = 1'b1;
          state_nxt = ST_ENTRY;
        end else if (start) state_nxt = ST_ARMED;
      end
      default: state_nxt = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state     <= ST_ENTRY;
      load_cnt  <= '0;
      entry_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_cnt  <= (state == ST_LOAD) ? load_cnt + 1'b1 : 2'd0;
      entry_err <= err_nxt;
      done      <= done_nxt;
    end
  end

  // Enable drops combinationally on zero so the chain never wraps past 00:00.
  assign run           = (state == ST_ARMED) && !timer_zero;
  assign loadn         = (state != ST_LOAD);
  assign state_o       = state;
  assign data_sec_ones = digits[0];
  assign data_sec_tens = digits[1];
  assign data_min_ones = digits[2];
  assign data_min_tens = digits[3];

endmodule

// File: tb/tb_time_entry_loader.sv
// Bench for time_entry_loader: directed scenarios plus randomized run against a decimal-value model.
module tb_time_entry_loader;
  logic       clock = 1'b0;
  logic       clearn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       start = 1'b0, stop = 1'b0, clear_entry = 1'b0, timer_zero = 1'b0;

  logic [3:0] d1_so, d1_st, d1_mo, d1_mt, d3_so, d3_st, d3_mo, d3_mt;
  logic       d1_loadn, d1_run, d1_err, d1_done, d3_loadn, d3_run, d3_err, d3_done;
  logic [1:0] d1_state, d3_state;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  time_entry_loader #(.LOAD_CYCLES(1)) u1 (
    .clock(clock), .clearn(clearn), .key_valid(key_valid), .key_code(key_code),
    .start(start), .stop(stop), .clear_entry(clear_entry), .timer_zero(timer_zero),
    .data_sec_ones(d1_so), .data_sec_tens(d1_st), .data_min_ones(d1_mo), .data_min_tens(d1_mt),
    .loadn(d1_loadn), .run(d1_run), .state_o(d1_state), .entry_err(d1_err), .done(d1_done));

  time_entry_loader #(.LOAD_CYCLES(3)) u3 (
    .clock(clock), .clearn(clearn), .key_valid(key_valid), .key_code(key_code),
    .start(start), .stop(stop), .clear_entry(clear_entry), .timer_zero(timer_zero),
    .data_sec_ones(d3_so), .data_sec_tens(d3_st), .data_min_ones(d3_mo), .data_min_tens(d3_mt),
    .loadn(d3_loadn), .run(d3_run), .state_o(d3_state), .entry_err(d3_err), .done(d3_done));

  // Reference model: entry held as a decimal number MMSS
  int m_state, m_val, m_cnt, m_lc;
  bit m_err, m_done;

  function automatic logic [15:0] val_digits(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic m_reset();
    m_state = 0; m_val = 0; m_cnt = 0; m_lc = 0; m_err = 0; m_done = 0;
  endtask

  task automatic m_step();
    bit n_err = 0, n_done = 0;
    case (m_state)
      0: if (clear_entry) begin m_val = 0; m_cnt = 0; end
         else if (start) begin
           if (((m_val / 10) % 10) <= 5 && m_val != 0) begin m_state = 1; m_lc = 0; end
           else n_err = 1;
         end else if (key_valid && key_code <= 9 && m_cnt < 4) begin
           m_val = (m_val * 10 + int'(key_code)) % 10000; m_cnt++;
         end
      1: if (clear_entry) begin m_val = 0; m_cnt = 0; m_state = 0; end
         else if (m_lc == 0) m_state = 2;
         else m_lc--;
      2: if (timer_zero) begin m_val = 0; m_cnt = 0; m_state = 0; n_done = 1; end
         else if (stop) m_state = 3;
      default: if (clear_entry) begin m_val = 0; m_cnt = 0; m_state = 0; end
               else if (start) m_state = 2;
    endcase
    m_err = n_err; m_done = n_done;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    key_valid = 0; start = 0; stop = 0; clear_entry = 0; timer_zero = 0;
    clearn = 0; tick(); clearn = 1; tick();
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1; key_code = k; tick(); key_valid = 0;
  endtask

  task automatic pulse_start(); start = 1; tick(); start = 0; endtask

  task automatic test_load_run();
    do_reset();
    press(1); press(2); press(3); press(0);
    checks++;
    if ({d1_mt, d1_mo, d1_st, d1_so} !== 16'h1230) begin
      errors++; $display("FAIL load_digits: got %h expected 1230", {d1_mt, d1_mo, d1_st, d1_so});
    end
    pulse_start();
    checks++;
    if ({d1_state, d1_loadn, d1_run} !== {2'd1, 1'b0, 1'b0} || {d1_mt, d1_mo, d1_st, d1_so} !== 16'h1230) begin
      errors++; $display("FAIL load_phase: got st=%0d loadn=%b run=%b data=%h expected st=1 loadn=0 run=0 data=1230",
                         d1_state, d1_loadn, d1_run, {d1_mt, d1_mo, d1_st, d1_so});
    end
    tick();
    checks++;
    if ({d1_state, d1_loadn, d1_run} !== {2'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL armed_run: got st=%0d loadn=%b run=%b expected st=2 loadn=1 run=1", d1_state, d1_loadn, d1_run);
    end
  endtask

  task automatic test_reset();
    #2; clearn = 0; #1;
    checks++;
    if ({d1_state, d1_loadn, d1_run, d1_mt, d1_mo, d1_st, d1_so} !== {2'd0, 1'b1, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL async_reset: got st=%0d loadn=%b run=%b data=%h expected st=0 loadn=1 run=0 data=0000",
                         d1_state, d1_loadn, d1_run, {d1_mt, d1_mo, d1_st, d1_so});
    end
    checks++;
    if ({d1_err, d1_done} !== 2'b00) begin
      errors++; $display("FAIL reset_pulses: got err=%b done=%b expected 0 0", d1_err, d1_done);
    end
    tick(); clearn = 1; tick();
  endtask

  task automatic test_saturation();
    do_reset();
    press(1); press(2); press(3); press(4); press(5);
    checks++;
    if ({d1_mt, d1_mo, d1_st, d1_so} !== 16'h1234) begin
      errors++; $display("FAIL fifth_key: got %h expected 1234", {d1_mt, d1_mo, d1_st, d1_so});
    end
    do_reset(); press(6); press(11);
    checks++;
    if ({d1_mt, d1_mo, d1_st, d1_so} !== 16'h0006) begin
      errors++; $display("FAIL bad_code: got %h expected 0006", {d1_mt, d1_mo, d1_st, d1_so});
    end
    press(1); press(2); press(3);
    clear_entry = 1; tick(); clear_entry = 0;
    checks++;
    if ({d1_mt, d1_mo, d1_st, d1_so} !== 16'h0000) begin
      errors++; $display("FAIL clear_entry: got %h expected 0000", {d1_mt, d1_mo, d1_st, d1_so});
    end
    press(7);
    checks++;
    if ({d1_mt, d1_mo, d1_st, d1_so} !== 16'h0007) begin
      errors++; $display("FAIL count_cleared: got %h expected 0007", {d1_mt, d1_mo, d1_st, d1_so});
    end
  endtask

  task automatic test_entry_err();
    do_reset();
    press(0); press(7); press(5);
    pulse_start();
    checks++;
    if ({d1_err, d1_state, d1_mt, d1_mo, d1_st, d1_so} !== {1'b1, 2'd0, 16'h0075}) begin
      errors++; $display("FAIL err_75: got err=%b st=%0d data=%h expected err=1 st=0 data=0075",
                         d1_err, d1_state, {d1_mt, d1_mo, d1_st, d1_so});
    end
    tick();
    checks++;
    if (d1_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b expected 0", d1_err); end
    clear_entry = 1; tick(); clear_entry = 0;
    pulse_start();
    checks++;
    if ({d1_err, d1_state} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL err_zero: got err=%b st=%0d expected err=1 st=0", d1_err, d1_state);
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    press(5); pulse_start(); tick();
    stop = 1; tick(); stop = 0;
    checks++;
    if ({d1_state, d1_run} !== {2'd3, 1'b0}) begin
      errors++; $display("FAIL pause: got st=%0d run=%b expected st=3 run=0", d1_state, d1_run);
    end
    pulse_start();
    checks++;
    if ({d1_state, d1_loadn, d1_run, d1_so} !== {2'd2, 1'b1, 1'b1, 4'd5}) begin
      errors++; $display("FAIL resume: got st=%0d loadn=%b run=%b so=%0d expected st=2 loadn=1 run=1 so=5",
                         d1_state, d1_loadn, d1_run, d1_so);
    end
    timer_zero = 1; #1;
    checks++;
    if ({d1_run, d1_done} !== 2'b00) begin
      errors++; $display("FAIL zero_gate: got run=%b done=%b expected 0 0", d1_run, d1_done);
    end
    tick(); timer_zero = 0;
    checks++;
    if ({d1_done, d1_state, d1_mt, d1_mo, d1_st, d1_so} !== {1'b1, 2'd0, 16'h0000}) begin
      errors++; $display("FAIL done: got done=%b st=%0d data=%h expected done=1 st=0 data=0000",
                         d1_done, d1_state, {d1_mt, d1_mo, d1_st, d1_so});
    end
    tick();
    checks++;
    if (d1_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", d1_done); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    press(4);
    start = 1; key_valid = 1; key_code = 4'd9; tick(); start = 0; key_valid = 0;
    checks++;
    if ({d1_state, d1_mt, d1_mo, d1_st, d1_so} !== {2'd1, 16'h0004}) begin
      errors++; $display("FAIL start_key: got st=%0d data=%h expected st=1 data=0004", d1_state, {d1_mt, d1_mo, d1_st, d1_so});
    end
    tick();
    timer_zero = 1; stop = 1; tick(); timer_zero = 0; stop = 0;
    checks++;
    if ({d1_done, d1_state} !== {1'b1, 2'd0}) begin
      errors++; $display("FAIL zero_stop: got done=%b st=%0d expected done=1 st=0", d1_done, d1_state);
    end
  endtask

  task automatic test_load3();
    int low = 0, overlap = 0;
    do_reset();
    press(2); pulse_start();
    for (int i = 0; i < 6; i++) begin
      if (d3_loadn === 1'b0) low++;
      if (d3_loadn === 1'b0 && d3_run !== 1'b0) overlap++;
      tick();
    end
    checks++;
    if (low != 3 || overlap != 0) begin
      errors++; $display("FAIL load3_len: got low=%0d overlap=%0d expected low=3 overlap=0", low, overlap);
    end
    checks++;
    if ({d3_state, d3_run} !== {2'd2, 1'b1}) begin
      errors++; $display("FAIL load3_armed: got st=%0d run=%b expected st=2 run=1", d3_state, d3_run);
    end
  endtask

  task automatic test_random();
    logic [24:0] got, exp;
    do_reset(); m_reset();
    for (int i = 0; i < 3000; i++) begin
      key_valid   = ($urandom % 2) == 0;
      key_code    = 4'($urandom % 16);
      start       = ($urandom % 6) == 0;
      stop        = ($urandom % 6) == 0;
      clear_entry = ($urandom % 14) == 0;
      timer_zero  = ($urandom % 8) == 0;
      @(negedge clock);
      got = {d1_state, d1_loadn, d1_run, d1_err, d1_done, d1_mt, d1_mo, d1_st, d1_so};
      exp = {2'(m_state), m_state != 1, m_state == 2 && !timer_zero, m_err, m_done, val_digits(m_val)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
      end
      m_step();
      tick();
    end
    key_valid = 0; start = 0; stop = 0; clear_entry = 0; timer_zero = 0;
  endtask

  initial begin
    test_load_run();
    test_reset();
    test_saturation();
    test_entry_err();
    test_pause_resume();
    test_same_cycle();
    test_load3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_entry_loader.md
Name: time_entry_loader

Overview:
Keypad-side front end of the timer chain. It accumulates up to four BCD digits (MM:SS) typed by the user and validates the entry. On start, it drives the parallel-load bus (data + loadn) of the decrementing digit counters (mod10/mod6 chain). It then gates the chain's count enable until the chain reports zero, and supports pause/resume.

Parameters:
LOAD_CYCLES, 1, number of consecutive clocks loadn is held low during a load (1..3)

Ports:
clock  in  1  system clock, all state on posedge
clearn  in  1  reset, asynchronous, active-low
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  BCD digit 0..9; codes 10..15 ignored
start  in  1  one-cycle pulse: start or resume
stop  in  1  one-cycle pulse: pause
clear_entry  in  1  one-cycle pulse: discard entry / abort paused run
timer_zero  in  1  high when whole counter chain reads 00:00
data_sec_ones  out  4  load value, seconds units (mod10 counter)
data_sec_tens  out  4  load value, seconds tens (mod6 counter)
data_min_ones  out  4  load value, minutes units
data_min_tens  out  4  load value, minutes tens
loadn  out  1  synchronous load to counters, active-low
run  out  1  count enable to least-significant counter, active-high
state_o  out  2  current FSM state for display/debug
entry_err  out  1  one-cycle pulse: rejected start
done  out  1  one-cycle pulse: countdown reached zero

Behaviour:
- Reset (clearn low, async): state ENTRY; all four digit registers 0; digit count 0; loadn=1; run=0; entry_err=0; done=0.
- Data outputs are the entry registers and are valid whenever loadn=0.
- States (state_o encoding): ENTRY=0, LOAD=1, ARMED=2, PAUSED=3.
- ENTRY:
  - key_valid with key_code<=9 and count<4: shift left (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_code); count+1.
  - count==4 or key_code>=10: key ignored, no change.
  - clear_entry: digits and count to 0.
  - start with sec_tens<=5 and entry nonzero: go to LOAD.
  - start with sec_tens>5 or all digits 0: entry_err=1 for one cycle; stay in ENTRY; digits kept.
- LOAD: loadn=0 and run=0 for exactly LOAD_CYCLES clocks, then ARMED. loadn is never low while run=1, because the counters ignore load while enabled. start/stop/keys ignored; clear_entry aborts to ENTRY after the current cycle and clears the digits.
- ARMED:
  - run = (state==ARMED) & ~timer_zero, combinational, so the chain never wraps 0->5/9.
  - timer_zero=1: next state ENTRY; done=1 for one cycle; digits and count cleared.
  - stop: PAUSED.
- PAUSED: run=0.
  - start: ARMED, no reload.
  - clear_entry: ENTRY, digits cleared, no done.
  - keys ignored.
- Priority, same cycle: clear_entry > start > key_valid (ENTRY); timer_zero > stop (ARMED). start+stop in ARMED: stop wins.
- entry_err and done are registered one-cycle pulses.
- No outputs depend on key inputs combinationally.

Decomposition:
- Shared timer package: state encoding constants (ENTRY/LOAD/ARMED/PAUSED), BCD limit constants (MAX_SEC_TENS=5, MAX_DIGIT=9), digit width 4, NUM_DIGITS=4.
- One natural sub-module: bcd_entry_shift, the 4-digit shift register with count, clear and saturation.
- FSM and load/run gating stay in the top.

Test Plan:
- Reset mid-ARMED: clearn low -> run=0, loadn=1, all data 0, state_o=0 asynchronously, before any clock edge.
- Keys 1,2,3,0 then start -> data 1,2,3,0 (MM=12, SS=30); loadn low 1 cycle with run=0; state_o 1->2; run=1 the next cycle.
- Keys 1,2,3,4,5 -> fifth key ignored, display 12:34. Key_code 11 ignored. Clear_entry -> 00:00.
- Keys 0,7,5 (SS=75) then start -> entry_err pulse one cycle, state stays 0, digits unchanged. Start with 00:00 -> entry_err.
- ARMED, stop -> run=0, state 3; start -> run=1 with no loadn pulse; timer_zero=1 -> run=0 same cycle, done pulse, state 0, digits 0.
- Same-cycle events: start+key_valid in ENTRY -> load, key not shifted. timer_zero+stop in ARMED -> done, state 0. LOAD_CYCLES=3 -> loadn low for exactly 3 clocks.
